// File: rtl/mux_pkg.sv
// Shared types and constants for the 4-lane byte serializer.
package mux_pkg;

  localparam int unsigned LANES  = 4;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WORD_W = LANES * BYTE_W;
  localparam int unsigned LANE_W = 2;

  typedef logic [LANE_W-1:0] lane_t;

  localparam lane_t LAST_LANE = lane_t'(LANES - 1);

  // One buffered word; element 0 is the lane-0 byte, sent first.
  typedef logic [LANES-1:0][BYTE_W-1:0] word_t;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } ser_state_e;

endpackage

// File: rtl/mux_word_fifo.sv
// Word buffer: DEPTH x 32-bit FIFO with push/pop, occupancy count and flags.
// DEPTH must be a power of two so the pointers wrap naturally.
module mux_word_fifo
  import mux_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  word_t            wdata,
  input  logic             pop,
  output word_t            rdata,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  word_t            mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (!reset && do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers and occupancy; push+pop together leaves count unchanged.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= PTR_W'(wr_ptr + 1'b1);
      end
      if (do_pop) begin
        rd_ptr <= PTR_W'(rd_ptr + 1'b1);
      end
      if (do_push && !do_pop) begin
        count <= CNT_W'(count + 1'b1);
      end else if (do_pop && !do_push) begin
        count <= CNT_W'(count - 1'b1);
      end
    end
  end

endmodule

// File: rtl/mux_4x1_8bits.sv
// 4-lane word to byte serializer with a DEPTH-entry word buffer.
// Optional: define MUX_OVF_FLAG_EN to add the sticky ovf_err output.
module mux_4x1_8bits
  import mux_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [BYTE_W-1:0] data_in0,
  input  logic [BYTE_W-1:0] data_in1,
  input  logic [BYTE_W-1:0] data_in2,
  input  logic [BYTE_W-1:0] data_in3,
  input  logic              validIn,
  output logic              readyIn,
  output logic [BYTE_W-1:0] data_out,
  output logic              validOut,
  input  logic              readyOut
`ifdef MUX_OVF_FLAG_EN
  ,
  output logic              ovf_err
`endif
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  ser_state_e        state_q, state_d;
  lane_t             lane_q, lane_d;
  word_t             word_q, word_d;
  logic [BYTE_W-1:0] dout_d;
  logic              vout_d;

  word_t             fifo_head;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_push;
  logic              fifo_pop;

  assign readyIn   = (fifo_count < CNT_W'(DEPTH));
  assign fifo_push = validIn & ~fifo_full;

  mux_word_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .wdata ({data_in3, data_in2, data_in1, data_in0}),
    .pop   (fifo_pop),
    .rdata (fifo_head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Serializer state register plus registered output byte and lane counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      lane_q   <= '0;
      word_q   <= '0;
      data_out <= '0;
      validOut <= 1'b0;
    end else begin
      state_q  <= state_d;
      lane_q   <= lane_d;
      word_q   <= word_d;
      data_out <= dout_d;
      validOut <= vout_d;
    end
  end

  // Next-state and next-output decode; loads a fresh word whenever the serializer frees up.
  always_comb begin
    state_d  = state_q;
    lane_d   = lane_q;
    word_d   = word_q;
    dout_d   = data_out;
    vout_d   = validOut;
    fifo_pop = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          word_d   = fifo_head;
          dout_d   = fifo_head[0];
          lane_d   = '0;
          vout_d   = 1'b1;
          state_d  = SEND;
        end
      end
      SEND: begin
        if (readyOut) begin
          if (lane_q == LAST_LANE) begin
            lane_d = '0;
            if (!fifo_empty) begin
              fifo_pop = 1'b1;
              word_d   = fifo_head;
              dout_d   = fifo_head[0];
            end else begin
              vout_d  = 1'b0;
              state_d = IDLE;
            end
          end else begin
            lane_d = lane_t'(lane_q + 1'b1);
            dout_d = word_q[lane_t'(lane_q + 1'b1)];
          end
        end
      end
      default: begin
        state_d = IDLE;
        vout_d  = 1'b0;
      end
    endcase
  end

`ifdef MUX_OVF_FLAG_EN
  // Sticky flag: a word was offered while the buffer could not take it.
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_err <= 1'b0;
    end else if (validIn && !readyIn) begin
      ovf_err <= 1'b1;
    end
  end
`endif

endmodule

// File: doc/mux_4x1_8bits.md
MUX_4X1_8BITS -- requirements
Module: mux_4x1_8bits

Interface
REQ-001 Parameter DEPTH, default 2, word-buffer entries (power of 2, >=2).
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 data_in0..data_in3  input  8 each  lane bytes of one word; lane 0 is sent first.
REQ-005 validIn  input  1  all four lanes hold a valid word.
REQ-006 readyIn  output  1  block can accept a word this cycle.
REQ-007 data_out  output  8  serialized byte.
REQ-008 validOut  output  1  data_out holds a valid byte.
REQ-009 readyOut  input  1  downstream accepts data_out this cycle.

Function
REQ-010 The block SHALL write a word when validIn && readyIn; this is a push.
REQ-011 The block SHALL set readyIn = (word count < DEPTH), decoded combinationally from the registered count.
REQ-012 A push when full SHALL NOT occur, because readyIn is low; a pop in the same cycle SHALL NOT raise readyIn until the next cycle.
REQ-013 The serializer state machine SHALL have two states: IDLE (validOut=0) and SEND (validOut=1), with a 2-bit lane counter lane_idx.
REQ-014 IDLE->SEND SHALL occur when the buffer is non-empty: pop the head word, drive data_out=lane0 byte, and set lane_idx=0.
REQ-015 In SEND, a byte SHALL be transferred when validOut && readyOut, and lane_idx SHALL then advance to the next lane byte.
REQ-016 In SEND with readyOut=0, data_out, validOut and lane_idx SHALL hold.
REQ-017 After the lane-3 byte transfers, lane_idx SHALL wrap to 0; if the buffer is non-empty, the next word's lane-0 byte SHALL load on the same edge and the state SHALL stay SEND; otherwise the state SHALL go to IDLE.
REQ-018 Latency: a word pushed in cycle N into an empty block SHALL show its lane-0 byte with validOut=1 in cycle N+2.
REQ-019 Throughput SHALL be one byte per cycle with no bubbles between words while readyOut=1 and the buffer is non-empty.
REQ-020 Output byte order SHALL equal push order, with lanes 0,1,2,3 within each word; no byte SHALL be dropped or duplicated.
REQ-021 The word count SHALL change by +1 on push only, -1 on pop only, and 0 on simultaneous push and pop.
REQ-022 Buffer read and write pointers SHALL wrap modulo DEPTH.

Reset
REQ-023 While reset=1 at a clock edge, the block SHALL clear: state=IDLE, lane_idx=0, count=0, pointers=0, data_out=8'h00, validOut=0.
REQ-024 readyIn SHALL read 1 in the first cycle after reset deasserts.
REQ-025 Reset asserted mid-word SHALL discard the partially sent word and all buffered words; no byte of them SHALL appear afterwards.
REQ-026 Pushes presented while reset=1 SHALL be ignored.

Configuration
REQ-027 With MUX_OVF_FLAG_EN defined, the block SHALL add an output port ovf_err (1 bit).
REQ-028 ovf_err SHALL set sticky on any cycle with validIn=1 && readyIn=0, and SHALL clear only on reset.
REQ-029 Without MUX_OVF_FLAG_EN, the port and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-030 Shared package mux_pkg SHALL hold: LANES=4, BYTE_W=8, lane index typedef (2 bits), serializer state enum {IDLE, SEND}.
REQ-031 The word buffer SHALL be the sub-module mux_word_fifo (DEPTH x 32 bits, push/pop/count/full/empty).
REQ-032 The serializer and lane counter SHALL live in the top module.

Verification
REQ-033 Single word: after reset, push 0x11,0x22,0x33,0x44 at cycle 0 with readyOut=1 -> data_out 11,22,33,44 in cycles 2-5, validOut=1 for those cycles only.
REQ-034 Back-to-back: push words A=(01,02,03,04) and B=(05,06,07,08) on consecutive cycles -> 8 consecutive valid bytes 01..08 with no gap.
REQ-035 Stall: readyOut=0 while data_out=0x22 for 3 cycles -> 0x22 held with validOut=1; 0x33 follows in the cycle after readyOut returns to 1.
REQ-036 Full: DEPTH=2, readyOut=0, push 3 words -> readyIn=0 after 2 stored words plus 1 word loaded in the serializer; with MUX_OVF_FLAG_EN, a validIn held high while full -> ovf_err=1 stays set.
REQ-037 Reset mid-word: assert reset after byte 0x22 transfers, then push (AA,BB,CC,DD) -> output AA,BB,CC,DD only; 0x33 and 0x44 never appear.
